// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
//   arb_state_e  - arbiter FSM encoding (IDLE=0, LOCK0=1, LOCK1=2)
//   PORT0/PORT1  - port identifiers as used by rr_last / rd_port
//   lock_state() - maps a winning port id to the matching LOCKn state
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam int   NUM_PORTS = 2;
  localparam logic PORT0     = 1'b0;
  localparam logic PORT1     = 1'b1;

  function automatic arb_state_e lock_state(input logic port);
    return (port == PORT1) ? LOCK1 : LOCK0;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: request/response bundle between the two requesters, the arbiter
// and the xbar port.
//   i_pN_*        requester N command (valid/addr/data/wren/mask/lock)
//   o_pN_ready    requester N accepted this cycle
//   o_pN_rvalid   requester N load data valid, o_pN_rdata the data
//   o_addr/o_data/o_wren/o_mask  command toward the xbar
//   i_data        xbar load data, valid the cycle after the address
//   o_pN_grants/o_pN_stalls      perf counters (zero unless enabled)
// Modports: slave = arbiter side, master = requester/xbar side.
interface mem_arb_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4,
  parameter int CNT_W  = 32
);

  logic              i_p0_valid;
  logic [ADDR_W-1:0] i_p0_addr;
  logic [DATA_W-1:0] i_p0_data;
  logic              i_p0_wren;
  logic [MASK_W-1:0] i_p0_mask;
  logic              i_p0_lock;
  logic              o_p0_ready;
  logic              o_p0_rvalid;
  logic [DATA_W-1:0] o_p0_rdata;

  logic              i_p1_valid;
  logic [ADDR_W-1:0] i_p1_addr;
  logic [DATA_W-1:0] i_p1_data;
  logic              i_p1_wren;
  logic [MASK_W-1:0] i_p1_mask;
  logic              i_p1_lock;
  logic              o_p1_ready;
  logic              o_p1_rvalid;
  logic [DATA_W-1:0] o_p1_rdata;

  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_data;
  logic              o_wren;
  logic [MASK_W-1:0] o_mask;
  logic [DATA_W-1:0] i_data;

  logic [CNT_W-1:0]  o_p0_grants;
  logic [CNT_W-1:0]  o_p0_stalls;
  logic [CNT_W-1:0]  o_p1_grants;
  logic [CNT_W-1:0]  o_p1_stalls;

  modport slave (
    input  i_p0_valid, i_p0_addr, i_p0_data, i_p0_wren, i_p0_mask, i_p0_lock,
    input  i_p1_valid, i_p1_addr, i_p1_data, i_p1_wren, i_p1_mask, i_p1_lock,
    input  i_data,
    output o_p0_ready, o_p0_rvalid, o_p0_rdata,
    output o_p1_ready, o_p1_rvalid, o_p1_rdata,
    output o_addr, o_data, o_wren, o_mask,
    output o_p0_grants, o_p0_stalls, o_p1_grants, o_p1_stalls
  );

  modport master (
    output i_p0_valid, i_p0_addr, i_p0_data, i_p0_wren, i_p0_mask, i_p0_lock,
    output i_p1_valid, i_p1_addr, i_p1_data, i_p1_wren, i_p1_mask, i_p1_lock,
    output i_data,
    input  o_p0_ready, o_p0_rvalid, o_p0_rdata,
    input  o_p1_ready, o_p1_rvalid, o_p1_rdata,
    input  o_addr, o_data, o_wren, o_mask,
    input  o_p0_grants, o_p0_stalls, o_p1_grants, o_p1_stalls
  );

endinterface

// File: rtl/mem_arb_perf.sv
// mem_arb_perf: saturating grant/stall counter pair for one arbiter port.
//   clk, rst  clock, synchronous active-high reset (clears both counters)
//   grant     port accepted this cycle
//   stall     port valid but not accepted this cycle
//   grants    accepted-transfer count, sticks at all-ones
//   stalls    stalled-cycle count, sticks at all-ones
module mem_arb_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             grant,
  input  logic             stall,
  output logic [CNT_W-1:0] grants,
  output logic [CNT_W-1:0] stalls
);

  logic [CNT_W-1:0] grants_reg;
  logic [CNT_W-1:0] stalls_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      grants_reg <= '0;
      stalls_reg <= '0;
    end else begin
      if (grant && (grants_reg != '1)) begin
        grants_reg <= grants_reg + 1'b1;
      end
      if (stall && (stalls_reg != '1)) begin
        stalls_reg <= stalls_reg + 1'b1;
      end
    end
  end

  assign grants = grants_reg;
  assign stalls = stalls_reg;

endmodule

// File: rtl/mem_arb.sv
// mem_arb: two-requester arbiter in front of the data-memory/MMIO xbar port.
// Port 0 is the CPU load/store unit, port 1 the debug/loader.
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   mem_arb_if.slave: both requester ports, the xbar command/data
//         signals and the perf counter outputs
// Round-robin grant between the ports, optional bus lock (requester keeps
// the grant while it holds i_pN_lock on its accepted transfers), and
// routing of the one-cycle-late xbar load data back to the issuing port.
// Optional feature macro: MEM_ARB_PERF_EN adds per-port saturating
// grant/stall counters; without it the counter outputs are tied to zero.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4,
  parameter int CNT_W  = 32
) (
  input logic      clk,
  input logic      rst,
  mem_arb_if.slave bus
);

  arb_state_e state_reg;
  arb_state_e state_next;

  logic rr_last_reg;   // port that won the most recent accept
  logic rd_pend_reg;   // a load was accepted last cycle
  logic rd_port_reg;   // which port issued that load

  logic [NUM_PORTS-1:0] valid_vec;
  logic [NUM_PORTS-1:0] ready_vec;
  logic                 accept;
  logic                 sel;

  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] data_sel;
  logic [MASK_W-1:0] mask_sel;
  logic              wren_sel;
  logic              lock_sel;

  assign valid_vec = {bus.i_p1_valid, bus.i_p0_valid};

  // Grant and next state. Nothing is granted while rst is high so that a
  // store presented in the reset cycle never reaches the xbar.
  always_comb begin
    ready_vec  = '0;
    state_next = state_reg;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (valid_vec == 2'b11) begin
            ready_vec = (rr_last_reg == PORT1) ? 2'b01 : 2'b10;
          end else begin
            ready_vec = valid_vec;
          end
        end
        LOCK0:   ready_vec = {1'b0, valid_vec[0]};
        LOCK1:   ready_vec = {valid_vec[1], 1'b0};
        default: ready_vec = '0;
      endcase
    end

    accept = |ready_vec;
    // With no accept this selects port 0, which keeps o_addr/o_data on
    // port 0's fields as the idle default.
    sel = ready_vec[1];
    lock_sel = sel ? bus.i_p1_lock : bus.i_p0_lock;

    // Lock only takes effect on an accepted transfer.
    if (accept) begin
      if ((state_reg == IDLE) && lock_sel) begin
        state_next = lock_state(sel);
      end else if ((state_reg != IDLE) && !lock_sel) begin
        state_next = IDLE;
      end
    end
  end

  always_comb begin
    addr_sel = sel ? bus.i_p1_addr : bus.i_p0_addr;
    data_sel = sel ? bus.i_p1_data : bus.i_p0_data;
    mask_sel = sel ? bus.i_p1_mask : bus.i_p0_mask;
    wren_sel = sel ? bus.i_p1_wren : bus.i_p0_wren;
  end

  // Downstream command: wren and mask are forced low without an accept.
  assign bus.o_addr     = addr_sel;
  assign bus.o_data     = data_sel;
  assign bus.o_wren     = accept && wren_sel;
  assign bus.o_mask     = accept ? mask_sel : '0;
  assign bus.o_p0_ready = ready_vec[0];
  assign bus.o_p1_ready = ready_vec[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // rr_last resets to port 1 so port 0 wins the first contest. The read
  // pipeline register is rewritten every cycle, so a response and a new
  // load accept in the same cycle do not interfere.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_reg <= PORT1;
      rd_pend_reg <= 1'b0;
      rd_port_reg <= PORT0;
    end else begin
      if (accept) begin
        rr_last_reg <= sel;
        rd_port_reg <= sel;
      end
      rd_pend_reg <= accept && !wren_sel;
    end
  end

  assign bus.o_p0_rvalid = rd_pend_reg && (rd_port_reg == PORT0);
  assign bus.o_p1_rvalid = rd_pend_reg && (rd_port_reg == PORT1);
  assign bus.o_p0_rdata  = bus.i_data;
  assign bus.o_p1_rdata  = bus.i_data;

  // Perf counters, one pair per port.
  logic [CNT_W-1:0] grants_vec [NUM_PORTS];
  logic [CNT_W-1:0] stalls_vec [NUM_PORTS];

  genvar gi;
`ifdef MEM_ARB_PERF_EN
  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_perf
    mem_arb_perf #(
      .CNT_W(CNT_W)
    ) u_perf (
      .clk    (clk),
      .rst    (rst),
      .grant  (ready_vec[gi]),
      .stall  (valid_vec[gi] && !ready_vec[gi]),
      .grants (grants_vec[gi]),
      .stalls (stalls_vec[gi])
    );
  end
`else
  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_perf_off
    assign grants_vec[gi] = '0;
    assign stalls_vec[gi] = '0;
  end
`endif

  assign bus.o_p0_grants = grants_vec[0];
  assign bus.o_p0_stalls = stalls_vec[0];
  assign bus.o_p1_grants = grants_vec[1];
  assign bus.o_p1_stalls = stalls_vec[1];

endmodule
